// File: rtl/cond_pkg.sv
// cond_pkg: shared condition codes, NZCV bit indices and flag-write type for the ARM condition unit.
package cond_pkg;
   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_e;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   typedef logic [1:0] flagw_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-field evaluation against NZCV flags.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);
   logic n, z, c, v, ge;
   assign n  = flags[FLAG_N];
   assign z  = flags[FLAG_Z];
   assign c  = flags[FLAG_C];
   assign v  = flags[FLAG_V];
   assign ge = (n == v);
   always_comb begin
      pass = 1'b0;
      case (cond_e'(cond))
         EQ: pass = z;
         NE: pass = ~z;
         CS: pass = c;
         CC: pass = ~c;
         MI: pass = n;
         PL: pass = ~n;
         VS: pass = v;
         VC: pass = ~v;
         HI: pass = c & ~z;
         LS: pass = ~c | z;
         GE: pass = ge;
         LT: pass = ~ge;
         GT: pass = ~z & ge;
         LE: pass = z | ~ge;
         AL: pass = 1'b1;
         NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, per-instruction condition capture and write-enable gating.
// Optional squashed-instruction counter enabled by COND_SQUASH_CNT_EN.
module cond_unit
   import cond_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  flagw_t     FlagW,
   input  logic       CondCapture,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CarryIn,
   output logic [3:0] Flags,
   output logic       CondEx
`ifdef COND_SQUASH_CNT_EN
   ,
   output logic [CNT_W-1:0] SquashCnt
`endif
);
   logic pass;
   cond_eval u_eval (.cond(Cond), .flags(Flags), .pass(pass));
   // flag writes are gated by the CondEx of the instruction already in flight
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         Flags  <= '0;
         CondEx <= 1'b0;
      end else begin
         if (CondCapture) CondEx <= pass;
         if (FlagW[1] & CondEx) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
         if (FlagW[0] & CondEx) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
`ifdef COND_SQUASH_CNT_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) SquashCnt <= '0;
      else if (CondCapture && !pass && !(&SquashCnt)) SquashCnt <= SquashCnt + 1'b1;
`endif
   assign RegWrite = RegW & CondEx;
   assign MemWrite = MemW & CondEx;
   assign PCWrite  = (PCS & CondEx) | NextPC;
   assign CarryIn  = Flags[FLAG_C];
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed self-checking bench for cond_unit.
module tb_cond_unit;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, ALUFlags;
   logic [1:0] FlagW;
   logic       CondCapture, PCS, NextPC, RegW, MemW;
   logic       PCWrite, RegWrite, MemWrite, CarryIn, CondEx;
   logic [3:0] Flags;
`ifdef COND_SQUASH_CNT_EN
   logic [1:0] SquashCnt;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   cond_unit #(.CNT_W(2)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .CondCapture(CondCapture), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .CarryIn(CarryIn),
      .Flags(Flags), .CondEx(CondEx)
`ifdef COND_SQUASH_CNT_EN
      , .SquashCnt(SquashCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n ~^ v;
         4'hB: return n ^ v;
         4'hC: return !z && (n ~^ v);
         4'hD: return z || (n ^ v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic capture(input logic [3:0] c);
      Cond = c;
      CondCapture = 1'b1;
      tick();
      CondCapture = 1'b0;
   endtask

   // leaves CondEx=1 and Flags=f
   task automatic set_flags(input logic [3:0] f);
      capture(4'hE);
      FlagW = 2'b11;
      ALUFlags = f;
      tick();
      FlagW = 2'b00;
   endtask

   initial begin
      reset = 1'b1; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
      CondCapture = 1'b0; PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
      tick();
      chk("rst_flags", 32'(Flags), 32'h0);
      chk("rst_condex", 32'(CondEx), 32'h0);
      reset = 1'b0;
      tick();

      for (int f = 0; f < 16; f++) begin
         set_flags(4'(f));
         chk("sweep_flags", 32'(Flags), 32'(f));
         for (int c = 0; c < 16; c++) begin
            capture(4'(c));
            chk($sformatf("cond_%0h_flags_%0h", c, f), 32'(CondEx), 32'(ref_cond(4'(c), 4'(f))));
         end
      end

      set_flags(4'b1001);
      capture(4'hA); chk("ex_ge", 32'(CondEx), 32'h1);
      capture(4'hC); chk("ex_gt", 32'(CondEx), 32'h1);
      capture(4'hB); chk("ex_lt", 32'(CondEx), 32'h0);

      set_flags(4'hF);
      chk("pre_rst_condex", 32'(CondEx), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_flags", 32'(Flags), 32'h0);
      chk("async_rst_condex", 32'(CondEx), 32'h0);
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
      #1;
      chk("rst_regwrite", 32'(RegWrite), 32'h0);
      chk("rst_memwrite", 32'(MemWrite), 32'h0);
      chk("rst_pcwrite_pcs", 32'(PCWrite), 32'h0);
      NextPC = 1'b1;
      #1;
      chk("rst_pcwrite_nextpc", 32'(PCWrite), 32'h1);
      tick();
      reset = 1'b0;
      NextPC = 1'b0;
      tick();
      chk("post_rst_regwrite", 32'(RegWrite), 32'h0);
      RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

      set_flags(4'h0);
      FlagW = 2'b10; ALUFlags = 4'b0110;
      tick();
      chk("half_nz", 32'(Flags), 32'b0100);
      FlagW = 2'b01; ALUFlags = 4'b1111;
      tick();
      chk("half_cv", 32'(Flags), 32'b0111);
      chk("carryin", 32'(CarryIn), 32'h1);
      FlagW = 2'b00; ALUFlags = 4'h0;
      tick();
      chk("hold_flags", 32'(Flags), 32'b0111);

      set_flags(4'h0);
      capture(4'h0);
      chk("eq_fail_condex", 32'(CondEx), 32'h0);
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF;
      tick();
      chk("gate_regwrite", 32'(RegWrite), 32'h0);
      chk("gate_memwrite", 32'(MemWrite), 32'h0);
      chk("gate_pcwrite", 32'(PCWrite), 32'h0);
      chk("gate_flags", 32'(Flags), 32'h0);
      FlagW = 2'b00;
      capture(4'hE);
      chk("pass_regwrite", 32'(RegWrite), 32'h1);
      chk("pass_memwrite", 32'(MemWrite), 32'h1);
      chk("pass_pcwrite", 32'(PCWrite), 32'h1);
      RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

      set_flags(4'h0);
      FlagW = 2'b10; ALUFlags = 4'b0100;
      capture(4'h0);
      FlagW = 2'b00;
      chk("same_cycle_condex", 32'(CondEx), 32'h0);
      chk("same_cycle_flags", 32'(Flags), 32'b0100);

`ifdef COND_SQUASH_CNT_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("squash_rst", 32'(SquashCnt), 32'h0);
      for (int i = 0; i < 5; i++) begin
         capture(4'hF);
         chk($sformatf("squash_%0d", i), 32'(SquashCnt), (i < 3) ? 32'(i + 1) : 32'h3);
      end
      capture(4'hE);
      chk("squash_al", 32'(SquashCnt), 32'h3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
Consumer end of the ALU flag interface in the multicycle ARM datapath.
- Holds the architectural NZCV flag register, written from the ALU's 4-bit flag output.
- Evaluates the 4-bit instruction condition field against the stored flags and captures the result once per instruction.
- Gates the controller's register, memory and PC write enables with the captured result.
- Returns the stored carry to the ALU's carry input.

Parameters:
- CNT_W, 16, width of the optional squashed-instruction counter (only used with COND_SQUASH_CNT_EN).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  ALU flag output: [3]=N, [2]=Z, [1]=C, [0]=V
- FlagW  input  2  controller flag-write request: [1] writes N,Z; [0] writes C,V
- CondCapture  input  1  one-cycle strobe from the controller in the Decode state
- PCS  input  1  instruction writes PC (branch or Rd=R15)
- NextPC  input  1  unconditional PC update (Fetch)
- RegW  input  1  controller register-write request
- MemW  input  1  controller memory-write request
- PCWrite  output  1  gated PC enable
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated memory write enable
- CarryIn  output  1  registered C flag, driven to the ALU carry input
- Flags  output  4  current NZCV register
- CondEx  output  1  captured condition result for the instruction in flight
- SquashCnt  output  CNT_W  squashed-instruction count (present only with COND_SQUASH_CNT_EN)

Behaviour:
Reset (asynchronous, active-high):
- Flags=0000, CondEx=0, SquashCnt=0.
- All gated enables are therefore 0, except that PCWrite follows NextPC.

Condition evaluation is combinational from Cond and the registered Flags. It is not taken from ALUFlags.
- 0000 EQ: Z. 0001 NE: ~Z.
- 0010 CS: C. 0011 CC: ~C.
- 0100 MI: N. 0101 PL: ~N.
- 0110 VS: V. 0111 VC: ~V.
- 1000 HI: C&~Z. 1001 LS: ~C|Z.
- 1010 GE: N==V. 1011 LT: N!=V.
- 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
- 1110 AL: 1. 1111 NV: 0.

CondEx register:
- Loads the evaluated result on the rising edge when CondCapture=1; holds otherwise.
- The value is valid from the cycle after Decode until the next capture, so flag updates in Execute never change the gating of the same instruction.

Flag register:
- On each rising edge, Flags[3:2] <= ALUFlags[3:2] if FlagW[1]&CondEx.
- On each rising edge, Flags[1:0] <= ALUFlags[1:0] if FlagW[0]&CondEx.
- The two halves update independently. With FlagW=00 the register holds.
- If CondCapture and a flag write occur in the same cycle, the capture evaluates the pre-update Flags and the write is gated by the old CondEx.

Gated enables (all combinational, no added latency):
- RegWrite = RegW & CondEx.
- MemWrite = MemW & CondEx.
- PCWrite = (PCS & CondEx) | NextPC. NextPC is never gated.

CarryIn = Flags[1], so flags written in cycle t are visible to the ALU in cycle t+1.

Reset mid-instruction clears CondEx. Any pending RegW/MemW/PCS write is suppressed until the next CondCapture.

Optional Feature:
Macro COND_SQUASH_CNT_EN.
- Defined: SquashCnt increments by 1 on each CondCapture where the evaluated condition is 0. It saturates at all-ones and is cleared by reset.
- Not defined: the SquashCnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
Shared package cond_pkg contains:
- Enum cond_e with the 16 condition codes.
- Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- The flagw_t 2-bit typedef.

Sub-module cond_eval is purely combinational: Cond, Flags -> pass. It is instantiated once in cond_unit and reusable by future pipelined control.

Test Plan:
- Reset mid-run with Flags=1111, CondEx=1 -> Flags=0000 and CondEx=0 immediately. RegW=1 gives RegWrite=0. NextPC=1 gives PCWrite=1.
- Sweep all 16 Cond values × all 16 Flags values with CondCapture pulses -> CondEx matches the table. Example: Flags=1001, Cond=1010 (GE) gives 1; Cond=1100 (GT) gives 1; Cond=1011 (LT) gives 0.
- CondEx=1, FlagW=10, ALUFlags=0110 -> Flags[3:2]=01 and Flags[1:0] unchanged. Next cycle FlagW=01, ALUFlags=1111 -> Flags=0111 and CarryIn=1.
- Cond=0000, Z=0, capture; then RegW=1, MemW=1, PCS=1, FlagW=11, ALUFlags=1111 -> RegWrite=MemWrite=PCWrite=0 and Flags unchanged.
- Same-cycle capture and flag write: Flags=0000, CondEx=1, FlagW=10, ALUFlags=0100, Cond=EQ, CondCapture=1 -> CondEx=0 (pre-update Z) and Flags=0100.
- With COND_SQUASH_CNT_EN and CNT_W=2: five captures of Cond=1111 -> SquashCnt sequence 1, 2, 3, 3, 3. Captures of Cond=1110 leave the count unchanged.
